// File: rtl/sensor_frame_pkg.sv
// sensor_frame_pkg
// Shared definitions for the sensor frame scheduler: default payload size,
// scheduler state encoding, statistics counter width and the pad byte that
// is returned whenever there is no frame byte to give the SPI shifter.
// Optional feature macro used by the scheduler files: FRAME_CHECKSUM_EN.
package sensor_frame_pkg;

    localparam int FRAME_BYTES_DEF = 32;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [7:0] PAD_BYTE = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SEND  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/frame_shadow_buf.sv
// frame_shadow_buf
// Shadow copy of one sensor frame. The whole packed frame is captured on a
// single load strobe; one byte is read out combinationally by index.
// Byte i of the frame lives in bits [8*i +: 8] of load_data_i.
// Optional feature macro: FRAME_CHECKSUM_EN (adds csum_o, the XOR of all
// stored payload bytes).
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (buffer cleared to 0x00)
//   load_i        capture load_data_i into the shadow this cycle
//   load_data_i   packed frame, FRAME_BYTES bytes
//   rd_idx_i      byte index to read
//   rd_data_o     shadow byte at rd_idx_i, pad byte when out of range
//   csum_o        XOR of stored bytes (FRAME_CHECKSUM_EN only)
module frame_shadow_buf
    import sensor_frame_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int IDX_W       = $clog2(FRAME_BYTES_DEF + 2)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_i,
    input  logic [8*FRAME_BYTES-1:0] load_data_i,
    input  logic [IDX_W-1:0]         rd_idx_i,
`ifdef FRAME_CHECKSUM_EN
    output logic [7:0]               csum_o,
`endif
    output logic [7:0]               rd_data_o
);

    logic [8*FRAME_BYTES-1:0] shadow_q;
    logic [8*FRAME_BYTES-1:0] shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (load_i) begin
            shadow_d = load_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        rd_data_o = PAD_BYTE;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                rd_data_o = shadow_q[8*i +: 8];
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    // Derived from the stored content, so an aborted-and-retried frame
    // still carries a checksum that matches what was actually sent.
    always_comb begin
        csum_o = 8'h00;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            csum_o = csum_o ^ shadow_q[8*i +: 8];
        end
    end
`endif

endmodule

// File: rtl/sensor_frame_scheduler.sv
// sensor_frame_scheduler
// Takes snapshots of packed sensor frames into a shadow buffer and hands
// them byte by byte to an SPI slave shifter while the MCU holds cs_n low.
// Optional feature macro: FRAME_CHECKSUM_EN (appends an XOR checksum byte,
// frame length becomes FRAME_BYTES+1).
//
// Handshakes:
//   src_ready/src_ack: the packer holds src_ready until it sees the one-cycle
//   src_ack pulse; a snapshot is taken on the edge where src_ready is seen
//   and src_ack is high the following cycle. src_ready seen while src_ack is
//   high is the same request and is ignored.
//   byte_req/tx_valid: every accepted byte_req yields exactly one tx_valid
//   pulse one cycle later with tx_byte; byte_req on the cycle cs_n is high
//   while sending is dropped.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   src_bytes     packed frame from packer (byte i at [8*i +: 8])
//   src_ready     packer has a new frame
//   src_ack       snapshot taken (pulse)
//   cs_n          MCU chip select, synchronous to clk
//   byte_req      shifter wants the next byte (pulse)
//   tx_byte       byte for the shifter
//   tx_valid      tx_byte valid (pulse)
//   frame_irq     a frame is armed and waiting for the MCU
//   overrun_cnt   saturating count of unread frames replaced by newer ones
//   abort_cnt     saturating count of reads cut short by cs_n
//   dbg_state_o   current scheduler state
module sensor_frame_scheduler
    import sensor_frame_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [8*FRAME_BYTES-1:0] src_bytes,
    input  logic                     src_ready,
    output logic                     src_ack,
    input  logic                     cs_n,
    input  logic                     byte_req,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    output logic                     frame_irq,
    output logic [CNT_W-1:0]         overrun_cnt,
    output logic [CNT_W-1:0]         abort_cnt,
    output logic [1:0]               dbg_state_o
);

    // Index must reach the frame length (FRAME_BYTES+1 with checksum).
    localparam int IDX_W = $clog2(FRAME_BYTES + 2);
`ifdef FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_BYTES + 1;
`else
    localparam int FRAME_LEN = FRAME_BYTES;
`endif
    localparam logic [IDX_W-1:0] LEN_IDX = IDX_W'(FRAME_LEN);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             src_ack_q, src_ack_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             frame_irq_q, frame_irq_d;
    logic [CNT_W-1:0] overrun_q, overrun_d;
    logic [CNT_W-1:0] abort_q, abort_d;

    logic       shadow_load;
    logic       can_load;
    logic [7:0] buf_data;
    logic [7:0] rd_byte;

`ifdef FRAME_CHECKSUM_EN
    logic [7:0] buf_csum;
`endif

    frame_shadow_buf #(
        .FRAME_BYTES (FRAME_BYTES),
        .IDX_W       (IDX_W)
    ) u_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (shadow_load),
        .load_data_i (src_bytes),
        .rd_idx_i    (idx_q),
`ifdef FRAME_CHECKSUM_EN
        .csum_o      (buf_csum),
`endif
        .rd_data_o   (buf_data)
    );

    always_comb begin
        rd_byte = buf_data;
`ifdef FRAME_CHECKSUM_EN
        if (idx_q == IDX_W'(FRAME_BYTES)) begin
            rd_byte = buf_csum;
        end
`endif
    end

    // The ack-cycle guard keeps a held src_ready from re-triggering.
    assign can_load = src_ready && cs_n && !src_ack_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        src_ack_d   = 1'b0;
        tx_valid_d  = 1'b0;
        tx_byte_d   = tx_byte_q;
        frame_irq_d = frame_irq_q;
        overrun_d   = overrun_q;
        abort_d     = abort_q;
        shadow_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (byte_req) begin
                    tx_valid_d = 1'b1;
                    tx_byte_d  = PAD_BYTE;
                end
                if (can_load) begin
                    shadow_load = 1'b1;
                    src_ack_d   = 1'b1;
                    frame_irq_d = 1'b1;
                    state_d     = ARMED;
                end
            end
            ARMED: begin
                if (byte_req) begin
                    tx_valid_d = 1'b1;
                    tx_byte_d  = PAD_BYTE;
                end
                // Chip select wins over a competing reload.
                if (!cs_n) begin
                    state_d     = SEND;
                    idx_d       = '0;
                    frame_irq_d = 1'b0;
                end else if (can_load) begin
                    shadow_load = 1'b1;
                    src_ack_d   = 1'b1;
                    if (overrun_q != CNT_MAX) begin
                        overrun_d = overrun_q + 1'b1;
                    end
                end
            end
            SEND: begin
                if (cs_n) begin
                    if (idx_q >= LEN_IDX) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = ARMED;
                        frame_irq_d = 1'b1;
                        if (abort_q != CNT_MAX) begin
                            abort_d = abort_q + 1'b1;
                        end
                    end
                end else if (byte_req) begin
                    tx_valid_d = 1'b1;
                    if (idx_q < LEN_IDX) begin
                        tx_byte_d = rd_byte;
                        idx_d     = idx_q + 1'b1;
                    end else begin
                        tx_byte_d = PAD_BYTE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            src_ack_q   <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= PAD_BYTE;
            frame_irq_q <= 1'b0;
            overrun_q   <= '0;
            abort_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            src_ack_q   <= src_ack_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
            frame_irq_q <= frame_irq_d;
            overrun_q   <= overrun_d;
            abort_q     <= abort_d;
        end
    end

    assign src_ack     = src_ack_q;
    assign tx_valid    = tx_valid_q;
    assign tx_byte     = tx_byte_q;
    assign frame_irq   = frame_irq_q;
    assign overrun_cnt = overrun_q;
    assign abort_cnt   = abort_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sensor_frame_scheduler.sv
// tb_sensor_frame_scheduler
// Directed bench for sensor_frame_scheduler. Expected tx bytes are pushed
// to exp_q when byte_req is driven and popped when tx_valid appears.
// Optional feature macro: FRAME_CHECKSUM_EN (must match the RTL build).
module tb_sensor_frame_scheduler;
    import sensor_frame_pkg::*;

    localparam int FB = 32;
`ifdef FRAME_CHECKSUM_EN
    localparam int LEN = FB + 1;
`else
    localparam int LEN = FB;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [8*FB-1:0] src_bytes = '0;
    logic            src_ready = 1'b0;
    logic            src_ack;
    logic            cs_n = 1'b1;
    logic            byte_req = 1'b0;
    logic [7:0]      tx_byte;
    logic            tx_valid;
    logic            frame_irq;
    logic [7:0]      overrun_cnt;
    logic [7:0]      abort_cnt;
    logic [1:0]      dbg_state;

    sensor_frame_scheduler #(.FRAME_BYTES(FB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_bytes   (src_bytes),
        .src_ready   (src_ready),
        .src_ack     (src_ack),
        .cs_n        (cs_n),
        .byte_req    (byte_req),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .frame_irq   (frame_irq),
        .overrun_cnt (overrun_cnt),
        .abort_cnt   (abort_cnt),
        .dbg_state_o (dbg_state)
    );

    // scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] stim [FB];
    logic [7:0] mdl  [FB];
    int         rd_idx_mdl = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         ack_cnt = 0;
    logic       ack_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // output monitor: tx bytes against the queue, src_ack pulse shape
    always @(negedge clk) begin : mon
        logic [7:0] b;
        if (rst_n && tx_valid) begin
            if (exp_q.size() == 0) begin
                chk("tx_unexpected", 32'd1, 32'd0);
            end else begin
                b = exp_q.pop_front();
                chk("tx_byte", {24'd0, tx_byte}, {24'd0, b});
            end
        end
        if (src_ack) begin
            ack_cnt++;
            chk("ack_single", {31'd0, ack_prev}, 32'd0);
        end
        ack_prev = src_ack;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timed out");
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_frame();
        for (int i = 0; i < FB; i++) begin
            src_bytes[8*i +: 8] = stim[i];
        end
    endtask

    function automatic logic [7:0] exp_byte(input int idx);
        logic [7:0] x;
        x = 8'h00;
        if (idx < FB) return mdl[idx];
`ifdef FRAME_CHECKSUM_EN
        if (idx == FB) begin
            for (int i = 0; i < FB; i++) x = x ^ mdl[i];
            return x;
        end
`endif
        return x;
    endfunction

    // Packer: raise src_ready, hold through the ack cycle, then drop.
    task automatic load_frame();
        int t;
        drive_frame();
        src_ready = 1'b1;
        t = 0;
        do begin
            tick();
            t++;
        end while (!src_ack && t < 10);
        chk("ack_seen", {31'd0, src_ack}, 32'd1);
        tick();
        src_ready = 1'b0;
        for (int i = 0; i < FB; i++) mdl[i] = stim[i];
    endtask

    task automatic begin_read();
        cs_n = 1'b0;
        rd_idx_mdl = 0;
        tick();
    endtask

    task automatic read_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_byte(rd_idx_mdl));
            if (rd_idx_mdl < LEN) rd_idx_mdl++;
            byte_req = 1'b1;
            tick();
            byte_req = 1'b0;
            tick();
        end
    endtask

    task automatic end_read();
        cs_n = 1'b1;
        tick();
    endtask

    task automatic full_cycle(input string tag);
        load_frame();
        chk({tag, "_irq"}, {31'd0, frame_irq}, 32'd1);
        begin_read();
        read_bytes(LEN + 1);
        end_read();
        chk({tag, "_idle"}, {30'd0, dbg_state}, {30'd0, IDLE});
    endtask

    int a0;

    initial begin
        // reset values
        for (int i = 0; i < FB; i++) stim[i] = 8'h00;
        tick(); tick();
        chk("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        chk("rst_ack", {31'd0, src_ack}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("rst_irq", {31'd0, frame_irq}, 32'd0);
        chk("rst_overrun", {24'd0, overrun_cnt}, 32'd0);
        chk("rst_abort", {24'd0, abort_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // byte_req in IDLE returns pad, no state change
        exp_q.push_back(8'h00);
        byte_req = 1'b1; tick(); byte_req = 1'b0; tick();
        chk("idle_req_state", {30'd0, dbg_state}, {30'd0, IDLE});

        // ascending frame, full readout plus one extra request
        for (int i = 0; i < FB; i++) stim[i] = 8'(i);
        a0 = ack_cnt;
        load_frame();
        chk("asc_ack_cnt", ack_cnt, a0 + 1);
        chk("asc_irq", {31'd0, frame_irq}, 32'd1);
        chk("asc_armed", {30'd0, dbg_state}, {30'd0, ARMED});
        begin_read();
        chk("asc_send", {30'd0, dbg_state}, {30'd0, SEND});
        chk("asc_irq_clr", {31'd0, frame_irq}, 32'd0);
        read_bytes(LEN + 1);
        end_read();
        chk("asc_idle", {30'd0, dbg_state}, {30'd0, IDLE});
        chk("asc_abort", {24'd0, abort_cnt}, 32'd0);
        chk("asc_overrun", {24'd0, overrun_cnt}, 32'd0);

        // checksum corner frames
        for (int i = 0; i < FB; i++) stim[i] = 8'h01;
        full_cycle("ones");
        for (int i = 0; i < FB; i++) stim[i] = 8'h00;
        stim[0] = 8'hA5;
        full_cycle("a5");

        // overrun: frame A replaced by frame B before cs_n falls
        for (int i = 0; i < FB; i++) stim[i] = 8'($urandom_range(0, 255));
        load_frame();
        for (int i = 0; i < FB; i++) stim[i] = 8'($urandom_range(0, 255));
        a0 = ack_cnt;
        load_frame();
        chk("ovr_ack_cnt", ack_cnt, a0 + 1);
        chk("ovr_cnt", {24'd0, overrun_cnt}, 32'd1);
        chk("ovr_irq", {31'd0, frame_irq}, 32'd1);
        begin_read();
        read_bytes(LEN + 1);
        end_read();
        chk("ovr_idle", {30'd0, dbg_state}, {30'd0, IDLE});

        // abort after 10 bytes; byte_req on the cs_n rise is dropped
        for (int i = 0; i < FB; i++) stim[i] = 8'($urandom_range(0, 255));
        load_frame();
        begin_read();
        read_bytes(10);
        cs_n = 1'b1;
        byte_req = 1'b1;
        tick();
        byte_req = 1'b0;
        tick();
        chk("abt_armed", {30'd0, dbg_state}, {30'd0, ARMED});
        chk("abt_cnt", {24'd0, abort_cnt}, 32'd1);
        chk("abt_irq", {31'd0, frame_irq}, 32'd1);
        begin_read();
        read_bytes(LEN + 1);
        end_read();
        chk("abt_retry_idle", {30'd0, dbg_state}, {30'd0, IDLE});
        chk("abt_cnt_hold", {24'd0, abort_cnt}, 32'd1);

        // cs_n fall and src_ready in the same ARMED cycle; src_ready in SEND
        for (int i = 0; i < FB; i++) stim[i] = 8'($urandom_range(0, 255));
        load_frame();
        for (int i = 0; i < FB; i++) stim[i] = ~mdl[i];
        drive_frame();
        a0 = ack_cnt;
        src_ready = 1'b1;
        cs_n = 1'b0;
        rd_idx_mdl = 0;
        tick();
        chk("race_send", {30'd0, dbg_state}, {30'd0, SEND});
        tick(); tick(); tick();
        chk("race_no_ack", ack_cnt, a0);
        chk("race_overrun", {24'd0, overrun_cnt}, 32'd1);
        src_ready = 1'b0;
        read_bytes(LEN + 1);
        end_read();
        chk("race_idle", {30'd0, dbg_state}, {30'd0, IDLE});

        // reset in the middle of SEND
        for (int i = 0; i < FB; i++) stim[i] = 8'($urandom_range(0, 255));
        load_frame();
        begin_read();
        read_bytes(5);
        a0 = ack_cnt;
        rst_n = 1'b0;
        cs_n = 1'b1;
        tick();
        chk("mrst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        chk("mrst_irq", {31'd0, frame_irq}, 32'd0);
        chk("mrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("mrst_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("mrst_overrun", {24'd0, overrun_cnt}, 32'd0);
        chk("mrst_abort", {24'd0, abort_cnt}, 32'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk("mrst_no_ack", ack_cnt, a0);
        for (int i = 0; i < FB; i++) stim[i] = 8'($urandom_range(0, 255));
        full_cycle("post_rst");
        chk("post_rst_ack", ack_cnt, a0 + 1);

        tick(); tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_frame_scheduler.md
SENSOR_FRAME_SCHEDULER -- requirements
Module: sensor_frame_scheduler

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 32, payload bytes per frame.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port src_bytes  input  8 x FRAME_BYTES  packed sensor frame from packer.
REQ-005 SHALL have port src_ready  input  1  packer has new data, held until acked.
REQ-006 SHALL have port src_ack  output  1  one-cycle pulse, snapshot taken.
REQ-007 SHALL have port cs_n  input  1  MCU chip select, already synchronized to clk.
REQ-008 SHALL have port byte_req  input  1  one-cycle pulse from SPI shifter, next tx byte needed.
REQ-009 SHALL have port tx_byte  output  8  byte for shifter.
REQ-010 SHALL have port tx_valid  output  1  one-cycle pulse, tx_byte valid.
REQ-011 SHALL have port frame_irq  output  1  level to MCU, frame armed.
REQ-012 SHALL have port overrun_cnt  output  8  saturating count of replaced unread frames.
REQ-013 SHALL have port abort_cnt  output  8  saturating count of CS-aborted frames.

Function
REQ-014 SHALL implement states IDLE, ARMED, SEND.
REQ-015 IDLE, src_ready=1, cs_n=1: SHALL load shadow buffer from src_bytes, pulse src_ack next cycle, enter ARMED, set frame_irq=1 the same edge.
REQ-016 ARMED, cs_n=1, src_ready=1: SHALL reload shadow (newest wins), pulse src_ack, increment overrun_cnt (saturate 255), stay ARMED.
REQ-017 ARMED, cs_n=0: SHALL enter SEND, index=0, clear frame_irq; cs_n=0 has priority over a same-cycle src_ready (no reload, no ack).
REQ-018 SEND, byte_req: SHALL drive tx_byte=shadow[index] with tx_valid pulse one cycle after byte_req, then index+1.
REQ-019 SEND, byte_req with index >= frame length: SHALL return 0x00 with tx_valid, index holds.
REQ-020 SEND, cs_n rises with index = frame length: SHALL enter IDLE.
REQ-021 SEND, cs_n rises with index < frame length: SHALL enter ARMED, retain shadow, reassert frame_irq, increment abort_cnt (saturate 255).
REQ-022 byte_req on the cycle cs_n rises SHALL be ignored (no tx_valid).
REQ-023 byte_req in IDLE or ARMED SHALL return 0x00 with tx_valid, no state change.
REQ-024 src_ready in SEND SHALL be ignored; src_ack never pulses in SEND.
REQ-025 src_ack SHALL never be high two consecutive cycles; src_ready sampled on the ack cycle SHALL not trigger a second snapshot.
REQ-026 index SHALL be wide enough for FRAME_BYTES+1 without wrap.

Reset
REQ-027 On rst_n low: state IDLE, src_ack=0, tx_valid=0, tx_byte=0x00, frame_irq=0, overrun_cnt=0, abort_cnt=0, index=0, shadow all 0x00.
REQ-028 Reset mid-SEND SHALL discard the frame; no ack issued afterwards for it.

Configuration
REQ-029 Macro FRAME_CHECKSUM_EN defined: frame length = FRAME_BYTES+1; final byte = XOR of all shadow payload bytes, computed from shadow content.
REQ-030 Macro FRAME_CHECKSUM_EN undefined: frame length = FRAME_BYTES; no checksum logic.

Structure
REQ-031 Package sensor_frame_pkg SHALL hold FRAME_BYTES default, state enum, counter width, pad byte 0x00.
REQ-032 Sub-module frame_shadow_buf SHALL hold the byte buffer (load strobe, read index, read data).

Verification
REQ-033 Packer frame bytes 0x00..0x1F, src_ready=1, cs_n=1 -> src_ack one pulse, frame_irq=1; cs_n low, 32 byte_req -> tx_byte 0x00..0x1F in order; cs_n high -> IDLE, abort_cnt=0.
REQ-034 Armed frame A, second src_ready with frame B before cs_n falls -> overrun_cnt=1; readout returns B.
REQ-035 cs_n high after 10 bytes -> abort_cnt=1, frame_irq=1; next transaction restarts at byte 0 with same data.
REQ-036 33rd byte_req without checksum -> 0x00; with FRAME_CHECKSUM_EN, frame 0x00..0x1F -> 33rd byte 0x00, frame all 0x01 -> 0x00, frame byte0=0xA5 rest 0 -> 0xA5.
REQ-037 cs_n fall and src_ready same cycle in ARMED -> enters SEND, no src_ack, overrun_cnt unchanged.
REQ-038 rst_n asserted after 5 bytes in SEND -> all outputs at reset values; later src_ready starts a fresh frame.
